// File: rtl/ct_arb_pkg.sv
// Shared encodings and helpers for the clause-table read arbiter.
// Holds the mode encoding and the requester-ID width helper.
package ct_arb_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_DRAIN = 2'd2
    } mode_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant plus encoded index.
// The pointer holds the highest-priority index for the next search.
module rr_arbiter
    import ct_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_width(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic          found;
    logic [IW-1:0] cand;
    int            sum;

    // Search starts at the pointer and wraps around once.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        sum       = 0;
        for (int i = 0; i < N; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IW'(sum);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/clause_table_arbiter.sv
// Clause-table lifecycle owner and round-robin read-port arbiter.
// Optional macro CT_ARB_PERF_CNT_EN adds grant and stall performance counters.
module clause_table_arbiter
    import ct_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int CT_WIDTH = 480,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                stop_i,
    output logic [1:0]                          mode_o,
    input  logic                                s_wr_en_i,
    input  logic [VARIABLE_ADDRESS_WIDTH-1:0]   s_wr_addr_i,
    input  logic [CT_WIDTH-1:0]                 s_wr_data_i,
    output logic                                wr_err_o,
    input  logic [N_REQ-1:0]                    req_valid_i,
    input  logic [N_REQ*VARIABLE_ADDRESS_WIDTH-1:0] req_addr_i,
    output logic [N_REQ-1:0]                    req_ready_o,
    output logic                                ct_wr_en_o,
    output logic [VARIABLE_ADDRESS_WIDTH-1:0]   ct_wr_addr_o,
    output logic [CT_WIDTH-1:0]                 ct_wr_data_o,
    output logic [VARIABLE_ADDRESS_WIDTH-1:0]   ct_rd_addr_o,
    input  logic [CT_WIDTH-1:0]                 ct_rd_data_i,
    output logic                                rsp_valid_o,
    output logic [ID_W-1:0]                     rsp_id_o,
    output logic [CT_WIDTH-1:0]                 rsp_data_o
`ifdef CT_ARB_PERF_CNT_EN
    ,
    output logic [N_REQ*32-1:0]                 perf_grant_cnt_o,
    output logic [31:0]                         perf_stall_cnt_o
`endif
);

    localparam int AW = VARIABLE_ADDRESS_WIDTH;

    mode_e          mode_q;
    mode_e          mode_d;
    logic           grant_en;
    logic           accept;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic           s1_valid_q;
    logic           s2_valid_q;
    logic [ID_W-1:0] s1_id_q;
    logic [ID_W-1:0] s2_id_q;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (req_valid_i),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // stop_i suppresses the grant in its own cycle so DRAIN only sees older reads.
    assign grant_en    = (mode_q == MODE_RUN) && !stop_i;
    assign req_ready_o = grant_en ? grant : '0;
    assign accept      = |(req_valid_i & req_ready_o);

    assign mode_o      = mode_q;
    assign rsp_valid_o = s2_valid_q;
    assign rsp_id_o    = s2_id_q;
    assign rsp_data_o  = ct_rd_data_i;

    // DRAIN never accepts, so once stage1 is empty both stages are empty next cycle.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_LOAD:  if (start_i)     mode_d = MODE_RUN;
            MODE_RUN:   if (stop_i)      mode_d = MODE_DRAIN;
            MODE_DRAIN: if (!s1_valid_q) mode_d = MODE_LOAD;
            default:                     mode_d = MODE_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q       <= MODE_LOAD;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s2_id_q      <= '0;
            ct_rd_addr_o <= '0;
            ct_wr_en_o   <= 1'b0;
            ct_wr_addr_o <= '0;
            ct_wr_data_o <= '0;
            wr_err_o     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            if (accept) begin
                s1_id_q      <= grant_idx;
                ct_rd_addr_o <= req_addr_i[int'(grant_idx)*AW +: AW];
            end
            ct_wr_en_o   <= s_wr_en_i && (mode_q == MODE_LOAD);
            ct_wr_addr_o <= s_wr_addr_i;
            ct_wr_data_o <= s_wr_data_i;
            if (s_wr_en_i && (mode_q != MODE_LOAD)) begin
                wr_err_o <= 1'b1;
            end
        end
    end

`ifdef CT_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt_q [N_REQ];
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (accept && req_ready_o[k] && (grant_cnt_q[k] != 32'hFFFF_FFFF)) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
                end
            end
            if ((mode_q == MODE_RUN) && (|req_valid_i) && !accept
                && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        perf_grant_cnt_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            perf_grant_cnt_o[k*32 +: 32] = grant_cnt_q[k];
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
